// File: rtl/pwm_sample_feeder.sv
// rtl/pwm_sample_feeder.sv - buffered sample source for pwm
// Samples queue in a small FIFO and are handed to pwm only at 256-cycle frame boundaries.
module pwm_sample_feeder #(
    parameter int DEPTH = 4,
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic [7:0]    in_sample,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          run,
    output logic [7:0]    sample,
    output logic          en,
    output logic          frame_tick,
    output logic          underrun,
    output logic [LW-1:0] level
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRIME,
        S_PLAY
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [7:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic [7:0]    r_frame_cnt;
    logic [7:0]    r_sample;
    logic          r_en;
    logic          r_underrun;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_boundary;
    logic [7:0]    w_head;
    logic [7:0]    w_sample_nxt;
    logic [7:0]    w_cnt_nxt;
    logic          w_en_nxt;
    logic          w_underrun_nxt;

    assign w_full     = (r_level == FULL_LVL);
    assign w_empty    = (r_level == '0);
    assign w_push     = in_valid && !w_full;
    assign w_head     = r_mem[r_rd_ptr];
    assign w_boundary = (r_state == S_PLAY) && (r_frame_cnt == 8'hFF);

    assign in_ready   = !w_full;
    assign level      = r_level;
    assign sample     = r_sample;
    assign en         = r_en;
    assign underrun   = r_underrun;
    assign frame_tick = w_boundary;

    // Storage is not reset; pointer and level reset is what discards the contents.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_sample;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state     <= S_IDLE;
            r_frame_cnt <= '0;
            r_sample    <= '0;
            r_en        <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_frame_cnt <= w_cnt_nxt;
            r_sample    <= w_sample_nxt;
            r_en        <= w_en_nxt;
            r_underrun  <= w_underrun_nxt;
        end
    end

    // The sample only changes on the last cycle of a frame, so a frame is never shortened.
    always_comb begin
        w_state_nxt    = r_state;
        w_pop          = 1'b0;
        w_sample_nxt   = r_sample;
        w_en_nxt       = r_en;
        w_cnt_nxt      = r_frame_cnt;
        w_underrun_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_sample_nxt = '0;
                w_en_nxt     = 1'b0;
                w_cnt_nxt    = '0;
                if (run && !w_empty) begin
                    w_state_nxt = S_PRIME;
                end
            end
            S_PRIME: begin
                w_pop        = 1'b1;
                w_sample_nxt = w_head;
                w_en_nxt     = 1'b1;
                w_cnt_nxt    = '0;
                w_state_nxt  = S_PLAY;
            end
            S_PLAY: begin
                w_cnt_nxt = r_frame_cnt + 8'd1;
                if (w_boundary) begin
                    if (!run) begin
                        w_state_nxt  = S_IDLE;
                        w_en_nxt     = 1'b0;
                        w_sample_nxt = '0;
                    end else if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_sample_nxt = w_head;
                    end else begin
                        w_underrun_nxt = 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_pwm_sample_feeder.sv
// tb/tb_pwm_sample_feeder.sv - self-checking bench for pwm_sample_feeder
// Queue-based reference model plus vector table and directed frame sequences.
module tb_pwm_sample_feeder;

    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          n_rst;
    logic [7:0]    in_sample;
    logic          in_valid;
    logic          in_ready;
    logic          run;
    logic [7:0]    sample;
    logic          en;
    logic          frame_tick;
    logic          underrun;
    logic [LW-1:0] level;

    pwm_sample_feeder #(.DEPTH(DEPTH), .LW(LW)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .in_sample  (in_sample),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .run        (run),
        .sample     (sample),
        .en         (en),
        .frame_tick (frame_tick),
        .underrun   (underrun),
        .level      (level)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int q[$];
    bit m_prime;
    bit m_play;
    int m_pos;
    int m_sample;
    bit m_en;
    bit m_under;

    typedef struct {
        bit         v;
        logic [7:0] d;
        bit         r;
        int         exp_level;
        bit         exp_ready;
        int         exp_sample;
        bit         exp_en;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        q.delete();
        m_prime  = 0;
        m_play   = 0;
        m_pos    = 0;
        m_sample = 0;
        m_en     = 0;
        m_under  = 0;
    endtask

    task automatic model_step(input bit v, input logic [7:0] d, input bit r);
        bit pushed;
        pushed  = v && (q.size() < DEPTH);
        m_under = 0;
        if (m_prime) begin
            m_sample = q.pop_front();
            m_en     = 1;
            m_pos    = 0;
            m_play   = 1;
            m_prime  = 0;
        end else if (m_play) begin
            if (m_pos == 255) begin
                if (!r) begin
                    m_play   = 0;
                    m_en     = 0;
                    m_sample = 0;
                end else if (q.size() > 0) begin
                    m_sample = q.pop_front();
                end else begin
                    m_under = 1;
                end
            end
            m_pos = (m_pos + 1) % 256;
        end else if (r && q.size() > 0) begin
            m_prime = 1;
        end
        if (pushed) q.push_back(int'(d));
    endtask

    task automatic cmp_model();
        chk("sample", sample, m_sample);
        chk("en", en, m_en);
        chk("frame_tick", frame_tick, m_play && (m_pos == 255));
        chk("underrun", underrun, m_under);
        chk("level", level, q.size());
        chk("in_ready", in_ready, q.size() < DEPTH);
    endtask

    // Called just after a falling edge: compare, drive, advance one clock.
    task automatic cyc(input bit v, input logic [7:0] d, input bit r);
        cmp_model();
        in_valid  = v;
        in_sample = d;
        run       = r;
        model_step(v, d, r);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_sample"}, sample, 0);
        chk({tag, "_en"}, en, 0);
        chk({tag, "_level"}, level, 0);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_tick"}, frame_tick, 0);
        chk({tag, "_underrun"}, underrun, 0);
    endtask

    task automatic do_reset();
        #10;
        n_rst = 1'b0;
        #1;
        chk_reset_outputs("rst_now");
        @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("rst_held");
        in_valid = 1'b0;
        run      = 1'b0;
        n_rst    = 1'b1;
        m_reset();
    endtask

    int ticks;
    int tick_at;
    int unders;
    int exp_frames[3];
    int prob[4];
    bit r_run;

    initial begin
        n_rst     = 1'b0;
        in_valid  = 1'b0;
        in_sample = '0;
        run       = 1'b0;
        m_reset();
        @(negedge clk);
        chk_reset_outputs("por");
        @(negedge clk);
        chk_reset_outputs("por_held");
        n_rst = 1'b1;

        // Backpressure table: fill to full with run low, then start playback
        tbl[0] = '{1, 8'd11, 0, 1, 1, 0, 0};
        tbl[1] = '{1, 8'd22, 0, 2, 1, 0, 0};
        tbl[2] = '{1, 8'd33, 0, 3, 1, 0, 0};
        tbl[3] = '{1, 8'd44, 0, 4, 0, 0, 0};
        tbl[4] = '{1, 8'd55, 0, 4, 0, 0, 0};
        tbl[5] = '{1, 8'd66, 1, 4, 0, 0, 0};
        tbl[6] = '{1, 8'd77, 1, 3, 1, 11, 1};
        tbl[7] = '{1, 8'd88, 1, 4, 0, 11, 1};
        for (int i = 0; i < 8; i++) begin
            cyc(tbl[i].v, tbl[i].d, tbl[i].r);
            chk($sformatf("tbl%0d_level", i), level, tbl[i].exp_level);
            chk($sformatf("tbl%0d_ready", i), in_ready, tbl[i].exp_ready);
            chk($sformatf("tbl%0d_sample", i), sample, tbl[i].exp_sample);
            chk($sformatf("tbl%0d_en", i), en, tbl[i].exp_en);
        end
        for (int i = 0; i < 255; i++) cyc(0, 0, 1);
        chk("bp_second_sample", sample, 22);
        chk("bp_level_after_pop", level, 3);
        for (int i = 0; i < 3 * 256; i++) cyc(0, 0, 1);
        chk("bp_last_sample", sample, 88);

        // Start latency, frame_tick position, underrun and late refill
        do_reset();
        cyc(1, 8'd127, 0);
        cyc(0, 0, 1);
        chk("start_en_not_yet", en, 0);
        cyc(0, 0, 1);
        chk("start_sample", sample, 127);
        chk("start_en", en, 1);
        chk("start_level", level, 0);
        ticks = 0;
        tick_at = -1;
        for (int i = 0; i < 256; i++) begin
            if (frame_tick) begin
                ticks++;
                tick_at = i;
            end
            cyc(0, 0, 1);
        end
        chk("tick_count", ticks, 1);
        chk("tick_cycle", tick_at, 255);
        chk("under_hold_sample", sample, 127);
        chk("under_pulse", underrun, 1);
        unders = 0;
        for (int i = 256; i < 512; i++) begin
            cyc(i == 300, 8'd200, 1);
            if (underrun) unders++;
        end
        chk("refill_sample", sample, 200);
        chk("no_extra_underrun", unders, 0);
        for (int i = 512; i < 768; i++) cyc(0, 0, 0);
        chk("stop_en", en, 0);

        // Frame-boundary updates only
        do_reset();
        exp_frames[0] = 127;
        exp_frames[1] = 255;
        exp_frames[2] = 0;
        cyc(1, 8'd127, 0);
        cyc(1, 8'd255, 0);
        cyc(1, 8'd0, 1);
        cyc(0, 0, 1);
        for (int i = 0; i < 768; i++) begin
            if (i % 256 == 0 || i % 256 == 255)
                chk($sformatf("frame_sample_c%0d", i), sample, exp_frames[i / 256]);
            cyc(0, 0, 1);
        end

        // Stop mid-frame, then resume with the next queued sample
        do_reset();
        cyc(1, 8'd10, 0);
        cyc(1, 8'd20, 0);
        cyc(1, 8'd30, 1);
        cyc(0, 0, 1);
        for (int i = 0; i < 256; i++) begin
            if (i == 255) begin
                chk("stop_hold_en", en, 1);
                chk("stop_hold_sample", sample, 10);
            end
            cyc(0, 0, i < 100);
        end
        chk("stopped_en", en, 0);
        chk("stopped_sample", sample, 0);
        chk("stopped_level", level, 2);
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        chk("resume_sample", sample, 20);
        for (int i = 0; i < 50; i++) cyc(0, 0, 1);
        do_reset();

        // Randomized traffic against the model
        prob[0] = 50;
        prob[1] = 400;
        prob[2] = 300;
        prob[3] = 60;
        r_run = 1'b1;
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < 2000; i++) begin
                if ($urandom_range(0, 599) == 0) r_run = !r_run;
                cyc($urandom_range(0, prob[s] - 1) == 0, 8'($urandom), r_run);
            end
        end
        cmp_model();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
